// File: rtl/mult_int6b_const.sv
// mult_int6b_const: signed 6-bit operand times an elaboration-time signed
// constant, full-precision 12-bit product, one register stage.
// The constant is recoded to canonical signed digit form at elaboration.
// The datapath is built only from shifted adds and subtracts of the
// sign-extended operand, so no general array multiplier is inferred.
//
// Handshake: in_valid qualifies inp on a rising edge. There is no
// back-pressure. out_valid is in_valid delayed by one edge. out updates
// only on accepted edges and holds otherwise.
module mult_int6b_const #(
  parameter int BIT_WIDTH = 6,
  parameter int OUT_WIDTH = 2 * BIT_WIDTH,
  parameter int COEFF     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIT_WIDTH-1:0] inp,
  input  logic                 in_valid,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 out_valid
);

  // CSD recoding of a signed constant.
  // neg = 0 returns the mask of +1 digits; neg = 1 returns the mask of -1 digits.
  // Each odd step picks the digit d in {+1, -1} that makes (x - d) divisible by 4.
  // This never leaves two adjacent nonzero digits.
  function automatic logic [OUT_WIDTH-1:0] csd_mask(input int c, input bit neg);
    int                   x;
    logic [OUT_WIDTH-1:0] m;
    x = c;
    m = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      if (x[0]) begin
        if (x[1]) begin
          if (neg) m[i] = 1'b1;
          x = x + 1;
        end else begin
          if (!neg) m[i] = 1'b1;
          x = x - 1;
        end
      end
      x = x >>> 1;
    end
    return m;
  endfunction

  localparam logic [OUT_WIDTH-1:0] POS_MASK = csd_mask(COEFF, 1'b0);
  localparam logic [OUT_WIDTH-1:0] NEG_MASK = csd_mask(COEFF, 1'b1);

  // Operand sign-extended to product width.
  // All chain arithmetic is modulo 2^OUT_WIDTH.
  // This keeps negative digits sign-correct at full width.
  logic [OUT_WIDTH-1:0] ext;
  assign ext = {{(OUT_WIDTH - BIT_WIDTH){inp[BIT_WIDTH-1]}}, inp};

  // Adder chain: stage i adds, subtracts or passes through the copy shifted by i.
  // Zero digits resolve to wires, so COEFF = 0 produces a constant 0.
  logic [OUT_WIDTH-1:0] chain [0:OUT_WIDTH];
  assign chain[0] = '0;

  for (genvar i = 0; i < OUT_WIDTH; i++) begin : g_digit
    if (POS_MASK[i]) begin : g_add
      assign chain[i+1] = chain[i] + (ext << i);
    end else if (NEG_MASK[i]) begin : g_sub
      assign chain[i+1] = chain[i] - (ext << i);
    end else begin : g_pass
      assign chain[i+1] = chain[i];
    end
  end

  logic [OUT_WIDTH-1:0] product;
  assign product = chain[OUT_WIDTH];

  // Output register: capture on accepted edges, hold otherwise, async clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out <= product;
    end
  end

endmodule

// File: tb/tb_mult_int6b_const.sv
// Testbench for mult_int6b_const.
// Five instances share one input stream, with COEFF = 3, 0, -32, 31 and -1.
module tb_mult_int6b_const;

  localparam int BW = 6;
  localparam int OW = 12;
  localparam int NI = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [BW-1:0] inp = '0;
  logic          in_valid = 1'b0;
  logic [OW-1:0] outs [NI];
  logic [NI-1:0] outv;

  int coeff_tab [NI] = '{3, 0, -32, 31, -1};

  mult_int6b_const #(.BIT_WIDTH(BW), .OUT_WIDTH(OW), .COEFF(3))
    dut_p3  (.clk(clk), .rst_n(rst_n), .inp(inp), .in_valid(in_valid), .out(outs[0]), .out_valid(outv[0]));
  mult_int6b_const #(.BIT_WIDTH(BW), .OUT_WIDTH(OW), .COEFF(0))
    dut_z   (.clk(clk), .rst_n(rst_n), .inp(inp), .in_valid(in_valid), .out(outs[1]), .out_valid(outv[1]));
  mult_int6b_const #(.BIT_WIDTH(BW), .OUT_WIDTH(OW), .COEFF(-32))
    dut_m32 (.clk(clk), .rst_n(rst_n), .inp(inp), .in_valid(in_valid), .out(outs[2]), .out_valid(outv[2]));
  mult_int6b_const #(.BIT_WIDTH(BW), .OUT_WIDTH(OW), .COEFF(31))
    dut_p31 (.clk(clk), .rst_n(rst_n), .inp(inp), .in_valid(in_valid), .out(outs[3]), .out_valid(outv[3]));
  mult_int6b_const #(.BIT_WIDTH(BW), .OUT_WIDTH(OW), .COEFF(-1))
    dut_m1  (.clk(clk), .rst_n(rst_n), .inp(inp), .in_valid(in_valid), .out(outs[4]), .out_valid(outv[4]));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [OW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h (%0d) exp=%0h (%0d)", tag, got, $signed(got), exp, $signed(exp));
    end
  endtask

  // Reference product, computed as a plain integer multiply.
  function automatic logic [OW-1:0] ref_mul(input logic [BW-1:0] a, input int c);
    int av;
    av = $signed(a);
    return OW'(av * c);
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge. Outputs are sampled 1 time unit after the rising edge.
  task automatic drive(input logic [BW-1:0] v, input logic vld);
    @(negedge clk);
    inp      = v;
    in_valid = vld;
  endtask

  task automatic sample_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("%s_out%0d", tag, k), outs[k], '0);
      check($sformatf("%s_vld%0d", tag, k), OW'(outv[k]), '0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held with a valid operand present: nothing may be captured.
    inp = 6'd5;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample_edge();
      check_all_zero($sformatf("rst_hold%0d", c));
    end
    drive(6'd5, 1'b0);
    rst_n = 1'b1;
    sample_edge();
    check_all_zero("post_rst_idle");

    // Basic: inp = 5.
    drive(6'd5, 1'b1);
    sample_edge();
    check("basic_p3",  outs[0], 12'h00F);
    check("basic_vld", OW'(outv[0]), 12'd1);
    check("basic_z",   outs[1], 12'h000);
    check("basic_m32", outs[2], 12'hF60);
    check("basic_p31", outs[3], 12'h09B);
    check("basic_m1",  outs[4], 12'hFFB);

    // Hold: in_valid low, inp changes; output keeps 15 and valid drops.
    drive(6'd7, 1'b0);
    sample_edge();
    check("hold_p3",  outs[0], 12'h00F);
    check("hold_vld", OW'(outv[0]), 12'd0);
    check("hold_m1",  outs[4], 12'hFFB);

    // Asynchronous reset pulse between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    #1;
    rst_n = 1'b1;
    sample_edge();
    check_all_zero("after_rst");

    // Directed signed vectors for COEFF = 3.
    drive(6'b100000, 1'b1);
    sample_edge();
    check("neg_extreme", outs[0], 12'hFA0);
    check("neg_ext_m32", outs[2], 12'h400);
    drive(6'b111111, 1'b1);
    sample_edge();
    check("minus_one", outs[0], 12'hFFD);
    drive(6'd31, 1'b1);
    sample_edge();
    check("pos_max",     outs[0], 12'h05D);
    check("pos_max_p31", outs[3], 12'h3C1);

    // Exhaustive back-to-back stream over all instances.
    for (int v = 0; v < 64; v++) begin
      for (int k = 0; k < NI; k++) exp_q.push_back(ref_mul(BW'(v), coeff_tab[k]));
      drive(BW'(v), 1'b1);
      sample_edge();
      for (int k = 0; k < NI; k++) begin
        if (exp_q.size() == 0) begin
          check($sformatf("sweep_q_empty_v%0d", v), '1, '0);
        end else begin
          check($sformatf("sweep_c%0d_v%0d", coeff_tab[k], v), outs[k], exp_q.pop_front());
        end
      end
      check($sformatf("sweep_vld_v%0d", v), OW'(outv), OW'({NI{1'b1}}));
    end
    drive(6'd0, 1'b0);
    sample_edge();
    check("final_vld", OW'(outv), '0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
